// File: rtl/mem_bus_arbiter_if.sv
// Memory bus arbiter port bundle: IF, MEM and external bus signals.
// The slave modport is the arbiter's view, master is the environment's.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  flush;

    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_addr_ok;
    logic                  inst_data_ok;
    logic [DATA_W-1:0]     inst_rdata;

    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    logic                  bus_req;
    logic                  bus_wr;
    logic [1:0]            bus_size;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_addr_ok;
    logic                  bus_data_ok;
    logic [DATA_W-1:0]     bus_rdata;

    logic                  stallreq_if;
    logic                  stallreq_mem;

    modport slave (
        input  flush,
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr,
        input  data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_addr,
        output bus_wstrb, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output stallreq_if, stallreq_mem
    );

    modport master (
        output flush,
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr,
        output data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_addr,
        input  bus_wstrb, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  stallreq_if, stallreq_mem
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and load/store,
// one outstanding transaction, data has priority, fetches can be flushed.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  port
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t                state;
    logic                  owner;
    logic                  cancel;
    logic                  req_q;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [DATA_W-1:0]     wdata_q;

    logic                  in_addr;
    logic                  in_data;
    logic                  inst_busy;
    logic                  data_busy;

    // Grant, latch the winning request and walk it through the bus phases.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            cancel  <= 1'b0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (port.data_req) begin
                        wr_q    <= port.data_wr;
                        size_q  <= port.data_size;
                        addr_q  <= port.data_addr;
                        wstrb_q <= port.data_wstrb;
                        wdata_q <= port.data_wdata;
                        owner   <= 1'b1;
                        req_q   <= 1'b1;
                        state   <= ADDR;
                    end else if (port.inst_req && !port.flush) begin
                        wr_q    <= 1'b0;
                        size_q  <= 2'd2;
                        addr_q  <= port.inst_addr;
                        wstrb_q <= '0;
                        wdata_q <= '0;
                        owner   <= 1'b0;
                        req_q   <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (port.flush && !owner) begin
                        cancel <= 1'b1;
                    end
                    if (port.bus_addr_ok) begin
                        req_q <= 1'b0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (port.bus_data_ok) begin
                        cancel <= 1'b0;
                        state  <= IDLE;
                    end else if (port.flush && !owner) begin
                        cancel <= 1'b1;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    assign port.bus_req   = req_q;
    assign port.bus_wr    = wr_q;
    assign port.bus_size  = size_q;
    assign port.bus_addr  = addr_q;
    assign port.bus_wstrb = wstrb_q;
    assign port.bus_wdata = wdata_q;

    // A cancelled fetch stays silent towards IF while it drains the bus.
    assign port.inst_addr_ok = in_addr & ~owner & ~cancel & port.bus_addr_ok;
    assign port.inst_data_ok = in_data & ~owner & ~cancel & port.bus_data_ok;
    assign port.data_addr_ok = in_addr & owner & port.bus_addr_ok;
    assign port.data_data_ok = in_data & owner & port.bus_data_ok;

    assign port.inst_rdata = port.bus_rdata;
    assign port.data_rdata = port.bus_rdata;

    assign inst_busy = (state != IDLE) & ~owner & ~cancel;
    assign data_busy = (state != IDLE) & owner;

    assign port.stallreq_if  = (port.inst_req | inst_busy)
                             & ~port.inst_data_ok & ~port.flush;
    assign port.stallreq_mem = (port.data_req | data_busy)
                             & ~port.data_data_ok;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change on the falling edge,
// outputs are checked 1 time unit later, state advances on the rising edge.
module tb_mem_bus_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ck(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus_if.flush       = 1'b0;
        bus_if.inst_req    = 1'b0;
        bus_if.inst_addr   = 32'h0;
        bus_if.data_req    = 1'b0;
        bus_if.data_wr     = 1'b0;
        bus_if.data_size   = 2'd0;
        bus_if.data_addr   = 32'h0;
        bus_if.data_wstrb  = 4'h0;
        bus_if.data_wdata  = 32'h0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b0;
        bus_if.bus_rdata   = 32'h0;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        quiet();
        next();
        next();
        rst = 1'b1;
        settle();
        ck("rst_bus_req",  32'(bus_if.bus_req), 32'h0);
        ck("rst_bus_addr", bus_if.bus_addr, 32'h0);
        ck("rst_stall_if", 32'(bus_if.stallreq_if), 32'h0);
        ck("rst_stall_mem", 32'(bus_if.stallreq_mem), 32'h0);

        // single fetch
        next();
        bus_if.inst_req  = 1'b1;
        bus_if.inst_addr = 32'hbfc00000;
        settle();
        ck("f1_n_bus_req", 32'(bus_if.bus_req), 32'h0);
        ck("f1_n_stall_if", 32'(bus_if.stallreq_if), 32'h1);
        next();
        bus_if.bus_addr_ok = 1'b1;
        settle();
        ck("f1_n1_bus_req", 32'(bus_if.bus_req), 32'h1);
        ck("f1_n1_bus_addr", bus_if.bus_addr, 32'hbfc00000);
        ck("f1_n1_bus_size", 32'(bus_if.bus_size), 32'h2);
        ck("f1_n1_addr_ok", 32'(bus_if.inst_addr_ok), 32'h1);
        next();
        bus_if.inst_req    = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata   = 32'h3c010001;
        settle();
        ck("f1_n2_bus_req", 32'(bus_if.bus_req), 32'h0);
        ck("f1_n2_data_ok", 32'(bus_if.inst_data_ok), 32'h1);
        ck("f1_n2_rdata", bus_if.inst_rdata, 32'h3c010001);
        ck("f1_n2_stall_if", 32'(bus_if.stallreq_if), 32'h0);
        next();
        quiet();
        settle();
        ck("f1_n3_data_ok", 32'(bus_if.inst_data_ok), 32'h0);

        // priority: store beats fetch
        next();
        bus_if.inst_req   = 1'b1;
        bus_if.inst_addr  = 32'hbfc00004;
        bus_if.data_req   = 1'b1;
        bus_if.data_wr    = 1'b1;
        bus_if.data_size  = 2'd2;
        bus_if.data_addr  = 32'h80000010;
        bus_if.data_wstrb = 4'hf;
        bus_if.data_wdata = 32'hdeadbeef;
        settle();
        ck("p0_stall_if", 32'(bus_if.stallreq_if), 32'h1);
        ck("p0_stall_mem", 32'(bus_if.stallreq_mem), 32'h1);
        next();
        bus_if.bus_addr_ok = 1'b1;
        settle();
        ck("p1_bus_req", 32'(bus_if.bus_req), 32'h1);
        ck("p1_bus_wr", 32'(bus_if.bus_wr), 32'h1);
        ck("p1_bus_addr", bus_if.bus_addr, 32'h80000010);
        ck("p1_bus_wdata", bus_if.bus_wdata, 32'hdeadbeef);
        ck("p1_bus_wstrb", 32'(bus_if.bus_wstrb), 32'hf);
        ck("p1_data_addr_ok", 32'(bus_if.data_addr_ok), 32'h1);
        ck("p1_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'h0);
        ck("p1_stall_if", 32'(bus_if.stallreq_if), 32'h1);
        next();
        bus_if.data_req    = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b1;
        settle();
        ck("p2_data_data_ok", 32'(bus_if.data_data_ok), 32'h1);
        ck("p2_stall_mem", 32'(bus_if.stallreq_mem), 32'h0);
        ck("p2_stall_if", 32'(bus_if.stallreq_if), 32'h1);
        next();
        bus_if.bus_data_ok = 1'b0;
        settle();
        ck("p3_bus_req", 32'(bus_if.bus_req), 32'h0);
        ck("p3_stall_if", 32'(bus_if.stallreq_if), 32'h1);
        next();
        bus_if.bus_addr_ok = 1'b1;
        settle();
        ck("p4_bus_req", 32'(bus_if.bus_req), 32'h1);
        ck("p4_bus_wr", 32'(bus_if.bus_wr), 32'h0);
        ck("p4_bus_addr", bus_if.bus_addr, 32'hbfc00004);
        ck("p4_bus_wstrb", 32'(bus_if.bus_wstrb), 32'h0);
        ck("p4_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'h1);
        next();
        bus_if.inst_req    = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata   = 32'h12345678;
        settle();
        ck("p5_inst_data_ok", 32'(bus_if.inst_data_ok), 32'h1);
        ck("p5_inst_rdata", bus_if.inst_rdata, 32'h12345678);
        next();
        quiet();

        // byte load at unaligned address
        bus_if.data_req  = 1'b1;
        bus_if.data_size = 2'd0;
        bus_if.data_addr = 32'h80000003;
        next();
        bus_if.bus_addr_ok = 1'b1;
        settle();
        ck("b1_bus_size", 32'(bus_if.bus_size), 32'h0);
        ck("b1_bus_addr", bus_if.bus_addr, 32'h80000003);
        ck("b1_bus_wr", 32'(bus_if.bus_wr), 32'h0);
        ck("b1_data_addr_ok", 32'(bus_if.data_addr_ok), 32'h1);
        ck("b1_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'h0);
        next();
        bus_if.data_req    = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata   = 32'h11223344;
        settle();
        ck("b2_data_data_ok", 32'(bus_if.data_data_ok), 32'h1);
        ck("b2_data_rdata", bus_if.data_rdata, 32'h11223344);
        ck("b2_inst_data_ok", 32'(bus_if.inst_data_ok), 32'h0);
        next();
        quiet();
        settle();
        ck("b3_data_data_ok", 32'(bus_if.data_data_ok), 32'h0);

        // flush while fetch is in DATA
        next();
        bus_if.inst_req  = 1'b1;
        bus_if.inst_addr = 32'hbfc00008;
        next();
        bus_if.bus_addr_ok = 1'b1;
        settle();
        ck("x1_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'h1);
        next();
        bus_if.inst_req    = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.flush       = 1'b1;
        settle();
        ck("x2_stall_if", 32'(bus_if.stallreq_if), 32'h0);
        ck("x2_inst_data_ok", 32'(bus_if.inst_data_ok), 32'h0);
        next();
        bus_if.flush = 1'b0;
        settle();
        ck("x3_stall_if", 32'(bus_if.stallreq_if), 32'h0);
        ck("x3_bus_req", 32'(bus_if.bus_req), 32'h0);
        next();
        bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata   = 32'h0badf00d;
        settle();
        ck("x4_inst_data_ok", 32'(bus_if.inst_data_ok), 32'h0);
        ck("x4_stall_if", 32'(bus_if.stallreq_if), 32'h0);
        next();
        bus_if.bus_data_ok = 1'b0;
        bus_if.bus_rdata   = 32'h0;
        bus_if.inst_req    = 1'b1;
        bus_if.inst_addr   = 32'hbfc0000c;
        settle();
        ck("x5_bus_req", 32'(bus_if.bus_req), 32'h0);
        ck("x5_stall_if", 32'(bus_if.stallreq_if), 32'h1);
        next();
        bus_if.bus_addr_ok = 1'b1;
        settle();
        ck("x6_bus_req", 32'(bus_if.bus_req), 32'h1);
        ck("x6_bus_addr", bus_if.bus_addr, 32'hbfc0000c);
        ck("x6_inst_addr_ok", 32'(bus_if.inst_addr_ok), 32'h1);
        next();
        bus_if.inst_req    = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata   = 32'h24020001;
        settle();
        ck("x7_inst_data_ok", 32'(bus_if.inst_data_ok), 32'h1);
        ck("x7_inst_rdata", bus_if.inst_rdata, 32'h24020001);
        next();
        quiet();

        // address phase wait states with a stray data_ok
        bus_if.data_req   = 1'b1;
        bus_if.data_wr    = 1'b1;
        bus_if.data_size  = 2'd1;
        bus_if.data_addr  = 32'h80000020;
        bus_if.data_wstrb = 4'h3;
        bus_if.data_wdata = 32'hcafef00d;
        for (int i = 0; i < 3; i++) begin
            next();
            bus_if.bus_data_ok = (i == 1);
            settle();
            ck("w_bus_req", 32'(bus_if.bus_req), 32'h1);
            ck("w_bus_addr", bus_if.bus_addr, 32'h80000020);
            ck("w_bus_wdata", bus_if.bus_wdata, 32'hcafef00d);
            ck("w_data_addr_ok", 32'(bus_if.data_addr_ok), 32'h0);
            ck("w_data_data_ok", 32'(bus_if.data_data_ok), 32'h0);
        end
        next();
        bus_if.bus_data_ok = 1'b0;
        bus_if.bus_addr_ok = 1'b1;
        settle();
        ck("w4_bus_req", 32'(bus_if.bus_req), 32'h1);
        ck("w4_bus_addr", bus_if.bus_addr, 32'h80000020);
        ck("w4_bus_size", 32'(bus_if.bus_size), 32'h1);
        ck("w4_data_addr_ok", 32'(bus_if.data_addr_ok), 32'h1);
        next();
        bus_if.data_req    = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b1;
        settle();
        ck("w5_data_data_ok", 32'(bus_if.data_data_ok), 32'h1);
        next();
        quiet();

        // reset while a fetch waits for data
        bus_if.inst_req  = 1'b1;
        bus_if.inst_addr = 32'hbfc00010;
        next();
        bus_if.bus_addr_ok = 1'b1;
        next();
        bus_if.inst_req    = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        rst = 1'b0;
        next();
        rst = 1'b1;
        settle();
        ck("r1_bus_req", 32'(bus_if.bus_req), 32'h0);
        ck("r1_bus_addr", bus_if.bus_addr, 32'h0);
        ck("r1_bus_size", 32'(bus_if.bus_size), 32'h0);
        ck("r1_stall_if", 32'(bus_if.stallreq_if), 32'h0);
        ck("r1_stall_mem", 32'(bus_if.stallreq_mem), 32'h0);
        ck("r1_inst_rdata", bus_if.inst_rdata, 32'h0);
        next();
        bus_if.bus_data_ok = 1'b1;
        bus_if.bus_rdata   = 32'h55aa55aa;
        settle();
        ck("r2_inst_data_ok", 32'(bus_if.inst_data_ok), 32'h0);
        ck("r2_data_data_ok", 32'(bus_if.data_data_ok), 32'h0);
        next();
        quiet();
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
